pipe_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It consumes the load-use hazard flag produced alongside operand forwarding, the EX-stage branch redirect, and the instruction/data memory readiness signals. It drives the write-enable and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It tracks in-flight wrong-path fetches across cycles and flags memory hangs with a watchdog.

---
 rtl/hazard_pkg.sv | 31 +++
 rtl/hazard_wdog.sv | 41 ++++
 rtl/pipe_hazard_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// rule-priority constants and watchdog defaults.
package hazard_pkg;

   // Registered sequencer state
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DWAIT = 2'd1,
      ST_IWAIT = 2'd2,
      ST_DROP  = 2'd3
   } hz_state_e;

   // Rule priority, lowest value wins when several conditions hold
   typedef enum logic [2:0] {
      RULE_DSTALL   = 3'd0,
      RULE_REDIRECT = 3'd1,
      RULE_DROP     = 3'd2,
      RULE_LOADUSE  = 3'd3,
      RULE_IWAIT    = 3'd4,
      RULE_RUN      = 3'd5
   } hz_rule_e;

   localparam int WAIT_TIMEOUT_DEF = 255;
   localparam int WDOG_W           = 16;

   // Cycles in which the pipeline is waiting on a memory
   function automatic logic is_wait_rule(hz_rule_e r);
      return (r == RULE_DSTALL) || (r == RULE_DROP) || (r == RULE_IWAIT);
   endfunction

endpackage

// File: rtl/hazard_wdog.sv
// Memory-hang watchdog: saturating count of consecutive wait cycles and a
// sticky error flag that only reset clears.
module hazard_wdog
   import hazard_pkg::*;
#(
   parameter int TIMEOUT = WAIT_TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic wait_i,
   output logic timeout_err_o
);

   localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT);

   logic [WDOG_W-1:0] cnt_q, cnt_d;
   logic              err_q, err_d;

   // Next count: clear on a non-wait cycle, otherwise count up to the limit
   always_comb begin
      cnt_d = '0;
      if (wait_i) begin
         cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
      end
      err_d = err_q | (cnt_d == LIMIT);
   end

   // Counter and sticky error registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign timeout_err_o = err_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Decodes hazard and
// memory-readiness inputs into stage write-enables and bubble flushes,
// tracks in-flight wrong-path fetches (DROP) and hosts the memory watchdog.
// Optional macro HAZARD_PERF_EN adds stall/redirect performance counters;
// without it the perf ports read 0 and no counter state exists.
module pipe_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEF,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_use_flag,
   input  logic             branch_taken_ex,
   input  logic             imem_ready,
   input  logic             dmem_busy,
   output logic             pc_we,
   output logic             if_id_we,
   output logic             id_ex_we,
   output logic             ex_mem_we,
   output logic             mem_wb_we,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             mem_wb_flush,
   output logic [1:0]       state,
   output logic             timeout_err,
   output logic [CNT_W-1:0] perf_stall_cnt,
   output logic [CNT_W-1:0] perf_flush_cnt
);

   hz_state_e state_q, state_d;
   hz_rule_e  rule;

   // Ungated controls; stage order {pc, if_id, id_ex, ex_mem, mem_wb}
   logic [4:0] we_raw;
   logic [2:0] fl_raw; // {if_id, id_ex, mem_wb}

   // Pick the single rule that governs this cycle
   always_comb begin
      if (dmem_busy)               rule = RULE_DSTALL;
      else if (branch_taken_ex)    rule = RULE_REDIRECT;
      else if (state_q == ST_DROP) rule = RULE_DROP;
      else if (load_use_flag)      rule = RULE_LOADUSE;
      else if (!imem_ready)        rule = RULE_IWAIT;
      else                         rule = RULE_RUN;
   end

   // Controls and next state for the selected rule
   always_comb begin
      we_raw  = 5'b11111;
      fl_raw  = 3'b000;
      state_d = ST_RUN;
      unique case (rule)
         RULE_DSTALL: begin
            // Freeze everything up to EX/MEM; MEM/WB takes a bubble
            we_raw  = 5'b00001;
            fl_raw  = 3'b001;
            state_d = (state_q == ST_DROP) ? ST_DROP : ST_DWAIT;
         end
         RULE_REDIRECT: begin
            fl_raw  = 3'b110;
            state_d = imem_ready ? ST_RUN : ST_DROP;
         end
         RULE_DROP: begin
            // PC holds the target so the refetch starts there
            we_raw  = 5'b01111;
            fl_raw  = 3'b100;
            state_d = imem_ready ? ST_RUN : ST_DROP;
         end
         RULE_LOADUSE: begin
            we_raw  = 5'b00111;
            fl_raw  = 3'b010;
         end
         RULE_IWAIT: begin
            we_raw  = 5'b01111;
            fl_raw  = 3'b100;
            state_d = ST_IWAIT;
         end
         default: ;
      endcase
   end

   // Reset forces every control low
   assign {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = rst_n ? we_raw : 5'b0;
   assign {if_id_flush, id_ex_flush, mem_wb_flush}         = rst_n ? fl_raw : 3'b0;

   // Sequencer state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_RUN;
      else        state_q <= state_d;
   end

   assign state = state_q;

   hazard_wdog #(
      .TIMEOUT (WAIT_TIMEOUT)
   ) u_wdog (
      .clk           (clk),
      .rst_n         (rst_n),
      .wait_i        (is_wait_rule(rule)),
      .timeout_err_o (timeout_err)
   );

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   // Free-running wrap-around counters of PC stalls and redirects
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (!we_raw[4])              stall_cnt_q <= stall_cnt_q + 1'b1;
         if (rule == RULE_REDIRECT)   flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   assign perf_stall_cnt = stall_cnt_q;
   assign perf_flush_cnt = flush_cnt_q;
`else
   assign perf_stall_cnt = '0;
   assign perf_flush_cnt = '0;
`endif

endmodule
